// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Requester side of the instruction memory interface. Owns the fetch PC,
// issues one word read at a time over a req/ack handshake and buffers the
// returned instructions, tagged with their PCs, in a DEPTH-entry FIFO for the
// decode stage. A redirect flushes the FIFO and restarts fetching at the new
// target. A response still in flight when the redirect arrives is waited
// out and discarded.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   mem_req_o      registered read request
//   mem_addr_o     registered byte address of the request (word aligned)
//   mem_ack_i      completes the current request
//   mem_data_i     instruction word, valid with mem_ack_i
//   redirect_i     flush and restart fetch
//   redirect_pc_i  new fetch PC (bits [1:0] forced to zero)
//   instr_valid_o  FIFO head valid
//   instr_o        instruction at FIFO head (0 when empty)
//   instr_pc_o     byte PC of instr_o (0 when empty)
//   instr_ready_i  consumer takes the head this cycle
//
// Build option
//   IFQ_BYPASS_EN  when defined, an accepted response arriving while the FIFO
//                  is empty is presented on instr_* in the ack cycle, and is
//                  only written into the FIFO if the consumer does not take it.
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

  // DROP: a request is still outstanding but its response must be thrown away.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]      fifo_instr_q [DEPTH];
  logic [31:0]      fifo_pc_q    [DEPTH];

  logic             ack_s;
  logic             accept_s;
  logic             empty_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;
  logic             space_s;
  logic [31:0]      pc_inc_s;
  logic [31:0]      redirect_addr_s;
  logic             unused_redirect_lsb_s;

  assign unused_redirect_lsb_s = ^redirect_pc_i[1:0];

  // Handshake qualification and FIFO push/pop decisions.
  always_comb begin
    ack_s           = req_q & mem_ack_i;
    accept_s        = ack_s & (state_q == ST_REQ) & ~redirect_i;
    empty_s         = (count_q == {CNT_W{1'b0}});
`ifdef IFQ_BYPASS_EN
    bypass_s        = accept_s & empty_s;
`else
    bypass_s        = 1'b0;
`endif
    // A bypassed response the consumer takes right away never enters the FIFO.
    push_s          = accept_s & ~(bypass_s & instr_ready_i);
    pop_s           = ~empty_s & instr_ready_i & ~redirect_i;
    pc_inc_s        = fetch_pc_q + 32'd4;
    redirect_addr_s = {redirect_pc_i[31:2], 2'b00};
  end

  // FIFO pointer and occupancy next state; a redirect empties the FIFO.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Free space after this cycle's push and pop decides whether to keep requesting.
  always_comb begin
    space_s = (count_d < CNT_W'(DEPTH));
  end

  // Fetch FSM next state, request and address registers.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_addr_s;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = redirect_addr_s;
        end
        ST_REQ, ST_DROP: begin
          if (ack_s) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = redirect_addr_s;
          end else begin
            // Old request stays on the bus until the memory answers it.
            state_d = ST_DROP;
            req_d   = 1'b1;
            addr_d  = addr_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          addr_d  = addr_q;
        end
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (space_s) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end else begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            fetch_pc_d = pc_inc_s;
            addr_d     = pc_inc_s;
            if (space_s) begin
              state_d = ST_REQ;
              req_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
              req_d   = 1'b0;
            end
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
          end
        end
        ST_DROP: begin
          // FIFO is empty in DROP, so there is always room to restart.
          if (ack_s) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end else begin
            state_d = ST_DROP;
            req_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // Control, address and FIFO bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_ADDR;
      fetch_pc_q <= RESET_ADDR;
      count_q    <= {CNT_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage: instruction word and its PC per entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]    <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_instr_q[wr_ptr_q] <= mem_data_i;
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  // Consumer-side outputs: bypassed response, FIFO head, or zeros when empty.
  always_comb begin
    if (bypass_s) begin
      instr_valid_o = 1'b1;
      instr_o       = mem_data_i;
      instr_pc_o    = addr_q;
    end else if (!empty_s) begin
      instr_valid_o = 1'b1;
      instr_o       = fifo_instr_q[rd_ptr_q];
      instr_pc_o    = fifo_pc_q[rd_ptr_q];
    end else begin
      instr_valid_o = 1'b0;
      instr_o       = 32'h0000_0000;
      instr_pc_o    = 32'h0000_0000;
    end
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  logic        tie_ack;
  logic        ack_drv;
  logic [31:0] data_drv;

  int errors = 0;
  int checks = 0;

  // Zero-wait memory mode: ack follows req, data = A000_0000 + address.
  assign mem_ack_i  = tie_ack ? mem_req_o : ack_drv;
  assign mem_data_i = tie_ack ? (32'hA000_0000 + mem_addr_o) : data_drv;

  always #5 clk_i = ~clk_i;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hA5A5_5A5A;
  endfunction

  // Leaves the bench at a negedge with reset just released.
  task automatic do_reset();
    rst_i         = 1'b0;
    tie_ack       = 1'b0;
    ack_drv       = 1'b0;
    data_drv      = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    int acks;
    int pops;
    int wait_left;
    logic [31:0] exp_pc;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;

    //           ack   data           rd    rpc            rdy   req   addr           v     instr          pc
    tbl[0]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         32'h0};
    tbl[1]  = '{1'b1, 32'hA000_0000, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0};
    tbl[2]  = '{1'b1, 32'hA000_0004, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hA000_0000, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'hA000_0004, 32'h4};
    tbl[4]  = '{1'b1, 32'hA000_0008, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'hA000_0004, 32'h4};
    tbl[5]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0103, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'hA000_0004, 32'h4};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0,         32'h0};
    tbl[7]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0,         32'h0};
    tbl[8]  = '{1'b1, 32'hA000_0100, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0};
    tbl[9]  = '{1'b1, 32'hA000_0104, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'hA000_0100, 32'h100};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         32'h0};
    tbl[11] = '{1'b1, 32'hA000_0200, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         32'h0};
    tbl[12] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0204, 1'b1, 32'hA000_0200, 32'h200};
    tbl[13] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0204, 1'b0, 32'h0,         32'h0};
    tbl[14] = '{1'b0, 32'h0,         1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0,         32'h0};
    tbl[15] = '{1'b0, 32'h0,         1'b1, 32'h0000_0400, 1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0,         32'h0};
    tbl[16] = '{1'b1, 32'h1234_5678, 1'b1, 32'h0000_0502, 1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0,         32'h0};
    tbl[17] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0500, 1'b0, 32'h0,         32'h0};

`ifndef IFQ_BYPASS_EN
    // ---------------- table-driven cycle vectors ----------------
    do_reset();
    for (int i = 0; i < 18; i++) begin
      ack_drv       = tbl[i].ack;
      data_drv      = tbl[i].data;
      redirect_i    = tbl[i].redir;
      redirect_pc_i = tbl[i].rpc;
      instr_ready_i = tbl[i].ready;
      #1;
      chk($sformatf("tbl%0d_req", i),   mem_req_o,     tbl[i].e_req);
      chk($sformatf("tbl%0d_addr", i),  mem_addr_o,    tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), instr_valid_o, tbl[i].e_valid);
      chk($sformatf("tbl%0d_instr", i), instr_o,       tbl[i].e_instr);
      chk($sformatf("tbl%0d_pc", i),    instr_pc_o,    tbl[i].e_pc);
      @(negedge clk_i);
    end
`endif

    // ---------------- zero-wait streaming, then PC wrap ----------------
    do_reset();
    tie_ack       = 1'b1;
    instr_ready_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (n == 0) begin
        chk("stream_req_first", mem_req_o, 32'd0);
      end else begin
        chk("stream_req", mem_req_o, 32'd1);
        chk("stream_addr", mem_addr_o, 32'(4 * (n - 1)));
      end
      if (n >= 1 + LAT) begin
        chk("stream_valid", instr_valid_o, 32'd1);
        chk("stream_pc", instr_pc_o, 32'(4 * (n - 1 - LAT)));
        chk("stream_data", instr_o, 32'hA000_0000 + 32'(4 * (n - 1 - LAT)));
      end else begin
        chk("stream_valid_early", instr_valid_o, 32'd0);
      end
      @(negedge clk_i);
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    @(negedge clk_i);
    redirect_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("wrap_addr", mem_addr_o, 32'hFFFF_FFF8 + 32'(4 * n));
      @(negedge clk_i);
    end

    // ---------------- backpressure ----------------
    do_reset();
    tie_ack       = 1'b1;
    instr_ready_i = 1'b0;
    acks          = 0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (mem_req_o) acks++;
      @(negedge clk_i);
    end
    chk("bp_acks", 32'(acks), 32'd4);
    instr_ready_i = 1'b1;
    #1;
    chk("bp_req_stalled", mem_req_o, 32'd0);
    chk("bp_head_valid", instr_valid_o, 32'd1);
    chk("bp_head_pc", instr_pc_o, 32'h0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk_i);
      #1;
      chk("bp_req_resumed", mem_req_o, 32'd1);
      chk("bp_pop_pc", instr_pc_o, 32'(4 * k));
    end
    @(negedge clk_i);

    // ---------------- reset during DROP, late ack ignored ----------------
    do_reset();
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    ack_drv  = 1'b1;
    data_drv = 32'h5555_0000;
    @(negedge clk_i);
    ack_drv       = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0040;
    @(negedge clk_i);
    redirect_i = 1'b0;
    #1;
    chk("drop_req_held", mem_req_o, 32'd1);
    chk("drop_addr_held", mem_addr_o, 32'h4);
    chk("drop_fifo_empty", instr_valid_o, 32'd0);
    #2;
    rst_i = 1'b0;
    #1;
    chk("rst_req", mem_req_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_valid", instr_valid_o, 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    @(negedge clk_i);
    rst_i    = 1'b1;
    ack_drv  = 1'b1;
    data_drv = 32'h7777_7777;
    #1;
    chk("late_ack_req", mem_req_o, 32'd0);
    chk("late_ack_valid", instr_valid_o, 32'd0);
    @(negedge clk_i);
    ack_drv = 1'b0;
    #1;
    chk("after_rst_req", mem_req_o, 32'd1);
    chk("after_rst_addr", mem_addr_o, 32'h0);
    chk("late_ack_dropped", instr_valid_o, 32'd0);
    @(negedge clk_i);

`ifdef IFQ_BYPASS_EN
    // ---------------- bypass: response shown in the ack cycle ----------------
    do_reset();
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    ack_drv  = 1'b1;
    data_drv = 32'h1111_2222;
    #1;
    chk("byp_valid", instr_valid_o, 32'd1);
    chk("byp_instr", instr_o, 32'h1111_2222);
    chk("byp_pc", instr_pc_o, 32'h0);
    @(negedge clk_i);
    ack_drv = 1'b0;
    #1;
    chk("byp_not_pushed", instr_valid_o, 32'd0);
    chk("byp_next_addr", mem_addr_o, 32'h4);
    @(negedge clk_i);
`endif

    // ---------------- randomized run against stream model ----------------
    do_reset();
    exp_pc    = 32'h0;
    pops      = 0;
    wait_left = $urandom_range(0, 3);
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'h0;
    for (int c = 0; c < 2000; c++) begin
      if (mem_req_o && wait_left == 0) begin
        ack_drv  = 1'b1;
        data_drv = mem_word(mem_addr_o);
      end else begin
        ack_drv  = 1'b0;
        data_drv = $urandom;
        if (mem_req_o) wait_left--;
      end
      instr_ready_i = ($urandom_range(0, 9) < 7);
      redirect_i    = ($urandom_range(0, 24) == 0);
      redirect_pc_i = $urandom;
      #1;
      if (prev_req && !prev_ack) begin
        chk("rnd_hold_req", mem_req_o, 32'd1);
        chk("rnd_hold_addr", mem_addr_o, prev_addr);
      end
      chk("rnd_addr_align", {30'd0, mem_addr_o[1:0]}, 32'h0);
      if (instr_valid_o && instr_ready_i && !redirect_i) begin
        chk("rnd_pop_pc", instr_pc_o, exp_pc);
        chk("rnd_pop_data", instr_o, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
      prev_req  = mem_req_o;
      prev_addr = mem_addr_o;
      prev_ack  = ack_drv;
      if (ack_drv) wait_left = $urandom_range(0, 3);
      @(negedge clk_i);
    end
    checks++;
    if (pops < 200) begin
      errors++;
      $display("FAIL rnd_progress: got %0d pops expected at least 200", pops);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
